// File: rtl/simplecpu_pkg.sv
// Shared SimpleCPU definitions: datapath widths, ALU op encoding and
// write-source select values used by both control unit and datapath.
package simplecpu_pkg;

    localparam int DATA_W    = 16;
    localparam int RF_ADDR_W = 4;
    localparam int DM_ADDR_W = 8;

    typedef enum logic {
        ALU_PASS = 1'b0,
        ALU_ADD  = 1'b1
    } alu_op_t;

    localparam logic RF_SRC_ALU = 1'b0;
    localparam logic RF_SRC_MEM = 1'b1;

endpackage

// File: rtl/simplecpu_datapath_if.sv
// Control-unit to datapath strobe bundle, plus the preload port and debug taps.
interface simplecpu_datapath_if
    import simplecpu_pkg::*;
();
    logic [DM_ADDR_W-1:0] D_addr;
    logic                 D_rd;
    logic                 D_wr;
    logic                 RF_s;
    logic [RF_ADDR_W-1:0] RF_W_addr;
    logic                 RF_W_wr;
    logic [RF_ADDR_W-1:0] RF_Rp_addr;
    logic                 RF_Rp_rd;
    logic [RF_ADDR_W-1:0] RF_Rq_addr;
    logic                 RF_Rq_rd;
    logic                 alu_s0;
    logic                 init_we;
    logic [DM_ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0]    init_data;
    logic [DATA_W-1:0]    rp_data;
    logic [DATA_W-1:0]    rq_data;
    logic [DATA_W-1:0]    alu_out;
    logic                 flag_z;
    logic                 flag_c;

    modport master (
        output D_addr, D_rd, D_wr, RF_s, RF_W_addr, RF_W_wr,
               RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, alu_s0,
               init_we, init_addr, init_data,
        input  rp_data, rq_data, alu_out, flag_z, flag_c
    );

    modport slave (
        input  D_addr, D_rd, D_wr, RF_s, RF_W_addr, RF_W_wr,
               RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, alu_s0,
               init_we, init_addr, init_data,
        output rp_data, rq_data, alu_out, flag_z, flag_c
    );

endinterface

// File: rtl/simplecpu_datapath_register_file.sv
// Two-read / one-write register file; gated combinational reads, no write bypass.
module register_file #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     w_addr,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    input  logic [AW-1:0]     rp_addr,
    input  logic              rp_en,
    output logic [DATA_W-1:0] rp_data,
    input  logic [AW-1:0]     rq_addr,
    input  logic              rq_en,
    output logic [DATA_W-1:0] rq_data
);

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (w_en) begin
            regs[w_addr] <= w_data;
        end
    end

    // Disabled ports read as zero so an idle port never feeds stale data downstream.
    assign rp_data = rp_en ? regs[rp_addr] : '0;
    assign rq_data = rq_en ? regs[rq_addr] : '0;

endmodule

// File: rtl/simplecpu_datapath.sv
// SimpleCPU execution datapath: register file, ALU, write-source mux,
// data memory and registered zero/carry flags.
module simplecpu_datapath
    import simplecpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int RF_DEPTH = 16,
    parameter int DM_DEPTH = 256
) (
    input logic                clk,
    input logic                rst,
    simplecpu_datapath_if.slave bus
);

    logic [DATA_W-1:0] rp_data, rq_data, alu_res, dm_rdata, wdata;
    logic              carry;
    logic              flag_z, flag_c;
    alu_op_t           alu_op;

    register_file #(.DATA_W(DATA_W), .DEPTH(RF_DEPTH)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .w_addr  (bus.RF_W_addr),
        .w_en    (bus.RF_W_wr),
        .w_data  (wdata),
        .rp_addr (bus.RF_Rp_addr),
        .rp_en   (bus.RF_Rp_rd),
        .rp_data (rp_data),
        .rq_addr (bus.RF_Rq_addr),
        .rq_en   (bus.RF_Rq_rd),
        .rq_data (rq_data)
    );

    assign alu_op = alu_op_t'(bus.alu_s0);

    always_comb begin
        carry   = 1'b0;
        alu_res = rp_data;
        case (alu_op)
            ALU_ADD:  {carry, alu_res} = {1'b0, rp_data} + {1'b0, rq_data};
            default:  ;
        endcase
    end

    // Data memory is deliberately not reset so a preload survives rst.
    logic [DATA_W-1:0] dm [DM_DEPTH];

    assign dm_rdata = bus.D_rd ? dm[bus.D_addr] : '0;

    // Single write port: preload has priority and a colliding store is dropped.
    always_ff @(posedge clk) begin
        if (bus.init_we)
            dm[bus.init_addr] <= bus.init_data;
        else if (bus.D_wr && !rst)
            dm[bus.D_addr] <= rp_data;
    end

    assign wdata = (bus.RF_s == RF_SRC_MEM) ? dm_rdata : alu_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (bus.RF_W_wr && bus.RF_s == RF_SRC_ALU) begin
            flag_z <= (alu_res == '0);
            flag_c <= carry;
        end
    end

    assign bus.rp_data = rp_data;
    assign bus.rq_data = rq_data;
    assign bus.alu_out = alu_res;
    assign bus.flag_z  = flag_z;
    assign bus.flag_c  = flag_c;

endmodule
